// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
//
// Downstream stage of the vending-machine controller. Every cycle it samples
// the upstream FSM's registered {purchase, cash_ret} pair and queues each
// non-null event in a small FIFO. Events are then served one at a time:
// the product motor first (vend_req / vend_done handshake), then one 5tk coin
// per hopper handshake (coin_req / coin_ack), with a fixed idle gap between
// consecutive coin requests. A missing acknowledge parks the block in FAULT
// until reset.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   purchase    in   1      product sold this cycle
//   cash_ret    in   2      change owed in 5tk units (0..3)
//   vend_done   in   1      product motor acknowledge
//   coin_ack    in   1      hopper acknowledge, one coin dropped
//   vend_req    out  1      product motor request (level)
//   coin_req    out  1      hopper request (level)
//   busy        out  1      FSM not idle or events still queued
//   fifo_level  out  LVL_W  number of queued events
//   overflow    out  1      sticky: an event was dropped on a full FIFO
//   fault       out  1      sticky: a handshake timed out
//   coin_count  out  CNT_W  total coins dispensed, wraps silently
// ---------------------------------------------------------------------------
module vm_change_dispenser #(
    parameter int DEPTH       = 4,
    parameter int LVL_W       = 3,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             purchase,
    input  logic [1:0]       cash_ret,
    input  logic             vend_done,
    input  logic             coin_ack,
    output logic             vend_req,
    output logic             coin_req,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic             fault,
    output logic [CNT_W-1:0] coin_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND,
        ST_COIN,
        ST_GAP,
        ST_FAULT
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [1:0]         coins_q,    coins_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               fault_q,    fault_d;
    logic               overflow_q, overflow_d;
    logic [LVL_W-1:0]   level_q,    level_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [2:0]         mem_q [DEPTH];

    logic [2:0] ev;
    logic       ev_valid;
    logic       push;
    logic       pop;
    logic [2:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Event FIFO
    // -----------------------------------------------------------------------
    assign ev       = {purchase, cash_ret};
    assign ev_valid = (ev != 3'b000);
    assign head     = mem_q[rd_ptr_q];
    assign pop      = (state_q == ST_IDLE) && (level_q != '0);
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push     = ev_valid && ((level_q != DEPTH_L) || pop);

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (ev_valid && !push) overflow_d = 1'b1;
    end

    // NOTE: the entry storage has no reset; emptiness is defined by level_q
    // and the pointers, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev;
    end

    // -----------------------------------------------------------------------
    // Dispense FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        count_d = count_q;
        fault_d = fault_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    coins_d = head[1:0];
                    tmo_d   = '0;
                    state_d = head[2] ? ST_VEND : ST_COIN;
                end
            end

            ST_VEND: begin
                // An ack in the final allowed cycle still wins over timeout.
                if (vend_done) begin
                    tmo_d   = '0;
                    state_d = (coins_q != 2'd0) ? ST_COIN : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_COIN: begin
                if (coin_ack) begin
                    coins_d = coins_q - 2'd1;
                    count_d = count_q + CNT_W'(1);
                    gap_d   = '0;
                    state_d = (coins_q != 2'd1) ? ST_GAP : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    tmo_d   = '0;
                    state_d = ST_COIN;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_FAULT: state_d = ST_FAULT;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            coins_q    <= 2'd0;
            tmo_q      <= '0;
            gap_q      <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            overflow_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            coins_q    <= coins_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decodes of registered state only
    // -----------------------------------------------------------------------
    assign vend_req   = (state_q == ST_VEND);
    assign coin_req   = (state_q == ST_COIN);
    assign busy       = (state_q != ST_IDLE) || (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign fault      = fault_q;
    assign coin_count = count_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vm_change_dispenser
//
// Table of single events (inputs, ack delay, expected pulse counts) applied in
// a loop, plus hand-written sequences for FIFO overflow, timeout and
// asynchronous reset. Every expected request pulse is pushed to a scoreboard
// queue when the event is driven and popped by the monitor on the request's
// rising edge. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vm_change_dispenser;

    localparam int DEPTH       = 4;
    localparam int LVL_W       = 3;
    localparam int GAP_CYCLES  = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             purchase;
    logic [1:0]       cash_ret;
    logic             vend_done;
    logic             coin_ack;
    logic             vend_req;
    logic             coin_req;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             fault;
    logic [CNT_W-1:0] coin_count;

    vm_change_dispenser #(
        .DEPTH(DEPTH), .LVL_W(LVL_W), .GAP_CYCLES(GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .purchase(purchase), .cash_ret(cash_ret),
        .vend_done(vend_done), .coin_ack(coin_ack), .vend_req(vend_req),
        .coin_req(coin_req), .busy(busy), .fifo_level(fifo_level),
        .overflow(overflow), .fault(fault), .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef enum int { K_VEND = 0, K_COIN = 1 } kind_e;
    typedef struct {
        kind_e kind;
        int    gap;   // low cycles since previous coin pulse; -1 = don't care
        int    len;   // high cycles of this pulse; -1 = don't care
    } exp_t;

    exp_t sb[$];

    int n_vend = 0;
    int n_coin = 0;
    int model_count = 0;

    // -----------------------------------------------------------------------
    // Auto-acknowledge responder: acks once a req has been seen high ack_dly
    // times, so the req stays high ack_dly+1 cycles.
    // -----------------------------------------------------------------------
    bit ack_en  = 1'b0;
    int ack_dly = 0;

    initial begin : responder
        int v_hi = 0;
        int c_hi = 0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                vend_done = vend_req && (v_hi >= ack_dly);
                coin_ack  = coin_req && (c_hi >= ack_dly);
            end
            v_hi = vend_req ? v_hi + 1 : 0;
            c_hi = coin_req ? c_hi + 1 : 0;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin : monitor
        logic v_prev = 1'b0;
        logic c_prev = 1'b0;
        int   v_len = 0, c_len = 0, c_low = 0;
        int   v_exp_len = -1, c_exp_len = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (vend_req && !v_prev) begin
                n_vend++;
                check("sb_has_entry_vend", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_kind_vend", 32'(e.kind), 32'(K_VEND));
                    v_exp_len = e.len;
                end
                v_len = 0;
            end
            if (vend_req) v_len++;
            if (!vend_req && v_prev && v_exp_len >= 0)
                check("vend_len", 32'(v_len), 32'(v_exp_len));

            if (coin_req && !c_prev) begin
                n_coin++;
                check("sb_has_entry_coin", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_kind_coin", 32'(e.kind), 32'(K_COIN));
                    if (e.gap >= 0) check("coin_gap", 32'(c_low), 32'(e.gap));
                    c_exp_len = e.len;
                end
                c_len = 0;
            end
            if (coin_req) begin
                c_len++;
                c_low = 0;
            end else begin
                c_low++;
            end
            if (!coin_req && c_prev && c_exp_len >= 0)
                check("coin_len", 32'(c_len), 32'(c_exp_len));

            v_prev = vend_req;
            c_prev = coin_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    typedef struct {
        bit       p;
        bit [1:0] cr;
        int       dly;
        int       nv;
        int       nc;
    } vec_t;

    task automatic push_expect(input bit p, input bit [1:0] cr, input int len);
        exp_t e;
        if (p) begin
            e.kind = K_VEND; e.gap = -1; e.len = len;
            sb.push_back(e);
        end
        for (int i = 0; i < int'(cr); i++) begin
            e.kind = K_COIN; e.gap = (i == 0) ? -1 : GAP_CYCLES; e.len = len;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge clk);
        check(name, 32'(busy), 0);
    endtask

    // One event into an idle block, with latency and completion checks.
    task automatic run_vector(input vec_t v);
        int v0, c0;
        v0 = n_vend;
        c0 = n_coin;
        ack_dly = v.dly;
        push_expect(v.p, v.cr, v.dly + 1);
        purchase = v.p;
        cash_ret = v.cr;
        @(negedge clk);
        purchase = 1'b0;
        cash_ret = 2'b00;
        check("lat_e0_reqs",  32'({vend_req, coin_req}), 0);
        check("lat_e0_level", 32'(fifo_level), 1);
        @(negedge clk);
        check("lat_e1_reqs",  32'({vend_req, coin_req}), v.p ? 32'd2 : 32'd1);
        wait_idle("vec_idle", 300);
        model_count += int'(v.cr);
        check("vec_vends",      32'(n_vend - v0), 32'(v.nv));
        check("vec_coins",      32'(n_coin - c0), 32'(v.nc));
        check("vec_coin_count", 32'(coin_count), 32'(model_count % (1 << CNT_W)));
        check("vec_sb_drained", 32'(sb.size()), 0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    vec_t vecs[5];

    initial begin : main
        vec_t v;
        reset     = 1'b0;
        purchase  = 1'b0;
        cash_ret  = 2'b00;
        vend_done = 1'b0;
        coin_ack  = 1'b0;

        vecs[0] = '{p: 1'b1, cr: 2'b00, dly: 3, nv: 1, nc: 0};  // product only
        vecs[1] = '{p: 1'b1, cr: 2'b11, dly: 1, nv: 1, nc: 3};  // product + 15tk
        vecs[2] = '{p: 1'b0, cr: 2'b01, dly: 0, nv: 0, nc: 1};  // 5tk refund
        vecs[3] = '{p: 1'b1, cr: 2'b10, dly: 0, nv: 1, nc: 2};
        vecs[4] = '{p: 1'b0, cr: 2'b11, dly: 2, nv: 0, nc: 3};

        repeat (3) @(negedge clk);
        check("rst_vend_req",   32'(vend_req), 0);
        check("rst_coin_req",   32'(coin_req), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        check("rst_overflow",   32'(overflow), 0);
        check("rst_fault",      32'(fault), 0);
        check("rst_coin_count", 32'(coin_count), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single events from the table.
        ack_en = 1'b1;
        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // coin_count wraps modulo 256 without any flag.
        v = '{p: 1'b0, cr: 2'b11, dly: 0, nv: 0, nc: 3};
        while (model_count < 260) run_vector(v);
        check("wrap_overflow", 32'(overflow), 0);
        check("wrap_fault",    32'(fault), 0);

        // Back-to-back events are served strictly in order.
        ack_dly = 0;
        push_expect(1'b1, 2'b01, 1);
        push_expect(1'b0, 2'b10, 1);
        push_expect(1'b1, 2'b00, 1);
        purchase = 1'b1; cash_ret = 2'b01; @(negedge clk);
        purchase = 1'b0; cash_ret = 2'b10; @(negedge clk);
        purchase = 1'b1; cash_ret = 2'b00; @(negedge clk);
        purchase = 1'b0; cash_ret = 2'b00;
        wait_idle("order_idle", 300);
        model_count += 3;
        check("order_coin_count", 32'(coin_count), 32'(model_count % (1 << CNT_W)));
        check("order_sb_drained", 32'(sb.size()), 0);

        // Overflow: six events with acks withheld; the sixth is dropped.
        ack_en = 1'b0; vend_done = 1'b0; coin_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH + 1) push_expect(1'b1, 2'b00, -1);
            purchase = 1'b1;
            @(negedge clk);
        end
        purchase = 1'b0;
        check("ovf_level",    32'(fifo_level), 32'(DEPTH));
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_vend_req", 32'(vend_req), 1);
        ack_en = 1'b1;
        ack_dly = 0;
        wait_idle("ovf_idle", 300);
        check("ovf_sticky",     32'(overflow), 1);
        check("ovf_drained",    32'(fifo_level), 0);
        check("ovf_sb_drained", 32'(sb.size()), 0);
        check("ovf_fault",      32'(fault), 0);

        // Timeout: 10tk refund, hopper never acknowledges.
        ack_en = 1'b0; vend_done = 1'b0; coin_ack = 1'b0;
        push_expect(1'b0, 2'b01, ACK_TIMEOUT);  // only the first coin is requested
        purchase = 1'b0; cash_ret = 2'b10;
        @(negedge clk);
        cash_ret = 2'b00;
        for (int i = 0; i < 60 && !fault; i++) @(negedge clk);
        check("tmo_fault",      32'(fault), 1);
        check("tmo_coin_req",   32'(coin_req), 0);
        check("tmo_busy",       32'(busy), 1);
        check("tmo_coin_count", 32'(coin_count), 32'(model_count % (1 << CNT_W)));
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_late_ack_count", 32'(coin_count), 32'(model_count % (1 << CNT_W)));
        check("tmo_late_ack_req",   32'(coin_req), 0);
        check("tmo_fault_sticky",   32'(fault), 1);
        check("tmo_sb_drained",     32'(sb.size()), 0);

        // Reset clears the fault.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_count = 0;
        @(negedge clk);
        check("rst2_fault",    32'(fault), 0);
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_busy",     32'(busy), 0);

        // Async reset mid-COIN with two events queued.
        ack_en = 1'b0; vend_done = 1'b0; coin_ack = 1'b0;
        begin
            exp_t e;
            e.kind = K_COIN; e.gap = -1;         e.len = 1;  sb.push_back(e);
            e.kind = K_COIN; e.gap = GAP_CYCLES; e.len = -1; sb.push_back(e);
        end
        purchase = 1'b0; cash_ret = 2'b11; @(negedge clk);
        purchase = 1'b1; cash_ret = 2'b00; @(negedge clk);
        purchase = 1'b0; cash_ret = 2'b01; coin_ack = 1'b1; @(negedge clk);
        purchase = 1'b0; cash_ret = 2'b00; coin_ack = 1'b0;
        for (int i = 0; i < 10 && !coin_req; i++) @(negedge clk);
        check("ar_coin_req",   32'(coin_req), 1);
        check("ar_level",      32'(fifo_level), 2);
        check("ar_coin_count", 32'(coin_count), 1);
        #2 reset = 1'b0;
        #1;
        check("ar_now_vend_req",   32'(vend_req), 0);
        check("ar_now_coin_req",   32'(coin_req), 0);
        check("ar_now_busy",       32'(busy), 0);
        check("ar_now_level",      32'(fifo_level), 0);
        check("ar_now_overflow",   32'(overflow), 0);
        check("ar_now_fault",      32'(fault), 0);
        check("ar_now_coin_count", 32'(coin_count), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ar_sb_drained", 32'(sb.size()), 0);

        // Normal service after release.
        ack_en = 1'b1;
        model_count = 0;
        v = '{p: 1'b1, cr: 2'b01, dly: 1, nv: 1, nc: 1};
        run_vector(v);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
